// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signal bundle for branch_resolve_queue.
// Optional BRQ_STATS_EN adds the statistics counters.
interface branch_resolve_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             alloc_valid;
    logic [31:0]      alloc_pc;
    logic             alloc_pred;
    logic [31:0]      alloc_target;
    logic             alloc_ready;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [31:0]      resolve_target;
    logic             upd_ld;
    logic             upd_br_en;
    logic [31:0]      upd_pc;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [PTR_W:0]   count;
    logic             resolve_err;
`ifdef BRQ_STATS_EN
    logic [31:0]      stat_resolved;
    logic [31:0]      stat_mispred;
`endif

    modport master (
        output alloc_valid, alloc_pc, alloc_pred, alloc_target,
        output resolve_valid, resolve_taken, resolve_target,
        input  alloc_ready, upd_ld, upd_br_en, upd_pc,
        input  mispredict, redirect_pc, count, resolve_err
`ifdef BRQ_STATS_EN
        , input stat_resolved, stat_mispred
`endif
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred, alloc_target,
        input  resolve_valid, resolve_taken, resolve_target,
        output alloc_ready, upd_ld, upd_br_en, upd_pc,
        output mispredict, redirect_pc, count, resolve_err
`ifdef BRQ_STATS_EN
        , output stat_resolved, stat_mispred
`endif
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; trains the global predictor and redirects on mispredict.
// Optional macro BRQ_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_upd_ld;
    logic               r_upd_br_en;
    logic [31:0]        r_upd_pc;
    logic               r_mispredict;
    logic [31:0]        r_redirect_pc;
    logic               r_resolve_err;

    entry_t             w_head_entry;
    logic               w_alloc_ready;
    logic               w_do_alloc;
    logic               w_do_resolve;
    logic               w_mispred;
    logic [31:0]        w_redirect;

    assign w_head_entry  = r_mem[r_head];
    assign w_alloc_ready = (r_count < CNT_W'(DEPTH));
    assign w_do_resolve  = bus.resolve_valid && (r_count != '0);
    assign w_mispred     = w_do_resolve &&
                           ((w_head_entry.pred != bus.resolve_taken) ||
                            (w_head_entry.pred && bus.resolve_taken &&
                             (w_head_entry.target != bus.resolve_target)));
    // A flush discards the same-cycle allocation along with every younger entry.
    assign w_do_alloc    = bus.alloc_valid && w_alloc_ready && !w_mispred;
    assign w_redirect    = bus.resolve_taken ? bus.resolve_target
                                             : (w_head_entry.pc + 32'd4);

    // Entry storage needs no reset; occupancy governs validity.
    always_ff @(posedge clk) begin
        if (w_do_alloc) begin
            r_mem[r_tail] <= '{pc: bus.alloc_pc, pred: bus.alloc_pred, target: bus.alloc_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispred) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_alloc) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_resolve) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_do_alloc, w_do_resolve})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Training and redirect outputs, one cycle after the resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_ld      <= 1'b0;
            r_upd_br_en   <= 1'b0;
            r_upd_pc      <= '0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_resolve_err <= 1'b0;
        end else begin
            r_upd_ld      <= w_do_resolve;
            r_upd_br_en   <= w_do_resolve && bus.resolve_taken;
            r_mispredict  <= w_mispred;
            r_resolve_err <= r_resolve_err || (bus.resolve_valid && (r_count == '0));
            if (w_do_resolve) begin
                r_upd_pc      <= w_head_entry.pc;
                r_redirect_pc <= w_redirect;
            end
        end
    end

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.upd_ld      = r_upd_ld;
    assign bus.upd_br_en   = r_upd_br_en;
    assign bus.upd_pc      = r_upd_pc;
    assign bus.mispredict  = r_mispredict;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.count       = r_count;
    assign bus.resolve_err = r_resolve_err;

`ifdef BRQ_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    // Saturating event counters keyed off the registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (r_upd_ld && (r_stat_resolved != 32'hFFFF_FFFF)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (r_mispredict && (r_stat_mispred != 32'hFFFF_FFFF)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign bus.stat_resolved = r_stat_resolved;
    assign bus.stat_mispred  = r_stat_mispred;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: driver pushes expected training pulses, monitor pops.
module tb_branch_resolve_queue;
    typedef struct {
        logic [31:0] pc;
        logic        br_en;
        logic        misp;
        logic [31:0] redirect;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   exp_res;
    int   exp_mis;
    exp_t sb[$];
    exp_t m_e;

    branch_resolve_queue_if #(.DEPTH(4)) bus ();

    branch_resolve_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid   = 1'b0;
        bus.resolve_valid = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        bus.alloc_valid  = 1'b1;
        bus.alloc_pc     = pc;
        bus.alloc_pred   = pred;
        bus.alloc_target = tgt;
    endtask

    task automatic set_resolve(input logic taken, input logic [31:0] tgt,
                               input logic [31:0] exp_pc, input logic exp_misp,
                               input logic [31:0] exp_red);
        exp_t e;
        bus.resolve_valid  = 1'b1;
        bus.resolve_taken  = taken;
        bus.resolve_target = tgt;
        e.pc = exp_pc; e.br_en = taken; e.misp = exp_misp; e.redirect = exp_red;
        sb.push_back(e);
        exp_res++;
        if (exp_misp) exp_mis++;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        set_alloc(pc, pred, tgt);
        bus.resolve_valid = 1'b0;
        cyc();
        idle();
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt, input logic [31:0] exp_pc,
                           input logic exp_misp, input logic [31:0] exp_red);
        bus.alloc_valid = 1'b0;
        set_resolve(taken, tgt, exp_pc, exp_misp, exp_red);
        cyc();
        idle();
    endtask

    // Monitor: every training pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.upd_ld === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL spurious_upd_ld actual pc=%h expected no pulse", bus.upd_pc);
                end else begin
                    m_e = sb.pop_front();
                    if (bus.upd_pc === m_e.pc && bus.upd_br_en === m_e.br_en &&
                        bus.mispredict === m_e.misp &&
                        (!m_e.misp || bus.redirect_pc === m_e.redirect))
                        n_pass++;
                    else
                        $display("FAIL upd_pulse actual pc=%h br=%b misp=%b red=%h expected pc=%h br=%b misp=%b red=%h",
                                 bus.upd_pc, bus.upd_br_en, bus.mispredict, bus.redirect_pc,
                                 m_e.pc, m_e.br_en, m_e.misp, m_e.redirect);
                end
            end else if (bus.mispredict !== 1'b0 || bus.upd_ld !== 1'b0) begin
                n_checks++;
                $display("FAIL lone_pulse actual ld=%b misp=%b expected 0/0", bus.upd_ld, bus.mispredict);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; exp_res = 0; exp_mis = 0;
        bus.alloc_pc = '0; bus.alloc_pred = 1'b0; bus.alloc_target = '0;
        bus.resolve_taken = 1'b0; bus.resolve_target = '0;
        idle();
        rst = 1'b1;
        // Reset wins over a simultaneous allocation.
        set_alloc(32'h0000_0999, 1'b0, '0);
        repeat (3) cyc();
        idle();
        rst = 1'b0;
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_ready", 32'(bus.alloc_ready), 32'd1);
        chk("reset_upd_ld", 32'(bus.upd_ld), 32'd0);
        chk("reset_upd_pc", bus.upd_pc, 32'd0);
        chk("reset_redirect", bus.redirect_pc, 32'd0);
        chk("reset_err", 32'(bus.resolve_err), 32'd0);

        // Single correct not-taken branch.
        alloc(32'h100, 1'b0, '0);
        chk("count_one", 32'(bus.count), 32'd1);
        resolve(1'b0, '0, 32'h100, 1'b0, 32'h104);
        chk("count_back_zero", 32'(bus.count), 32'd0);

        // Fill, drop a fifth, drain in order.
        alloc(32'h10, 1'b0, '0);
        alloc(32'h20, 1'b0, '0);
        alloc(32'h30, 1'b0, '0);
        alloc(32'h40, 1'b0, '0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.alloc_ready), 32'd0);
        alloc(32'h500, 1'b0, '0);
        chk("full_drop_count", 32'(bus.count), 32'd4);
        resolve(1'b0, '0, 32'h10, 1'b0, 32'h14);
        resolve(1'b0, '0, 32'h20, 1'b0, 32'h24);
        resolve(1'b0, '0, 32'h30, 1'b0, 32'h34);
        resolve(1'b0, '0, 32'h40, 1'b0, 32'h44);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_ready", 32'(bus.alloc_ready), 32'd1);

        // Direction mispredict flushes younger entries.
        alloc(32'h200, 1'b0, '0);
        alloc(32'h210, 1'b0, '0);
        alloc(32'h220, 1'b0, '0);
        resolve(1'b1, 32'h400, 32'h200, 1'b1, 32'h400);
        chk("flush_count", 32'(bus.count), 32'd0);
        alloc(32'h600, 1'b0, '0);
        resolve(1'b0, '0, 32'h600, 1'b0, 32'h604);

        // Target mispredict, taken-predicted-but-not-taken, and a correct taken.
        alloc(32'h300, 1'b1, 32'h340);
        resolve(1'b1, 32'h380, 32'h300, 1'b1, 32'h380);
        alloc(32'h300, 1'b1, 32'h340);
        resolve(1'b0, 32'h0, 32'h300, 1'b1, 32'h304);
        alloc(32'h700, 1'b1, 32'h740);
        resolve(1'b1, 32'h740, 32'h700, 1'b0, 32'h740);
        chk("taken_ok_count", 32'(bus.count), 32'd0);

        // Full queue: simultaneous alloc and correct resolve drops the allocation.
        alloc(32'h10, 1'b0, '0);
        alloc(32'h20, 1'b0, '0);
        alloc(32'h30, 1'b0, '0);
        alloc(32'h40, 1'b0, '0);
        set_alloc(32'h900, 1'b0, '0);
        set_resolve(1'b0, '0, 32'h10, 1'b0, 32'h14);
        cyc();
        idle();
        chk("full_both_count", 32'(bus.count), 32'd3);
        resolve(1'b0, '0, 32'h20, 1'b0, 32'h24);
        resolve(1'b0, '0, 32'h30, 1'b0, 32'h34);
        resolve(1'b0, '0, 32'h40, 1'b0, 32'h44);

        // Simultaneous alloc and mispredicting resolve.
        alloc(32'hA0, 1'b0, '0);
        alloc(32'hB0, 1'b0, '0);
        set_alloc(32'hC0, 1'b0, '0);
        set_resolve(1'b1, 32'h800, 32'hA0, 1'b1, 32'h800);
        cyc();
        idle();
        chk("misp_both_count", 32'(bus.count), 32'd0);

        // Non-full simultaneous alloc and correct resolve both take effect.
        alloc(32'hD0, 1'b0, '0);
        set_alloc(32'hE0, 1'b0, '0);
        set_resolve(1'b0, '0, 32'hD0, 1'b0, 32'hD4);
        cyc();
        idle();
        chk("both_count", 32'(bus.count), 32'd1);
        resolve(1'b0, '0, 32'hE0, 1'b0, 32'hE4);

        // Resolve while empty: no pulse, sticky error.
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        cyc();
        idle();
        chk("empty_err", 32'(bus.resolve_err), 32'd1);
        chk("empty_count", 32'(bus.count), 32'd0);
        repeat (3) cyc();
        chk("err_sticky", 32'(bus.resolve_err), 32'd1);

`ifdef BRQ_STATS_EN
        chk("stat_resolved", bus.stat_resolved, 32'(exp_res));
        chk("stat_mispred", bus.stat_mispred, 32'(exp_mis));
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight conditional-branch predictions, between fetch (allocation) and execute (resolution).
- On resolution, compares the actual outcome with the stored prediction.
- Emits a one-cycle training pulse (load, taken, pc) to the global branch predictor, plus a mispredict redirect/flush to the front end.
- Supplies the predictor's load-enable, outcome and pc inputs.

Parameters:
DEPTH, 4, number of in-flight entries; power of two, 2..16
PTR_W, $clog2(DEPTH), pointer width; derived, do not override

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
alloc_valid  input  1  fetch allocates a predicted branch this cycle
alloc_pc  input  32  pc of the allocated branch
alloc_pred  input  1  predicted direction (1 = taken)
alloc_target  input  32  predicted target; meaningful only when alloc_pred=1
alloc_ready  output  1  queue can accept an allocation (count < DEPTH)
resolve_valid  input  1  execute resolves the oldest branch this cycle
resolve_taken  input  1  actual direction
resolve_target  input  32  actual taken target
upd_ld  output  1  predictor training pulse (drives glob_pred_ld)
upd_br_en  output  1  actual direction for training (drives cpu_br_en)
upd_pc  output  32  pc of the trained branch
mispredict  output  1  one-cycle redirect/flush pulse
redirect_pc  output  32  correct next pc; valid while mispredict=1
count  output  PTR_W+1  current occupancy
resolve_err  output  1  sticky: resolve_valid seen while empty

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, pred, target}; head (oldest) and tail pointers wrap at DEPTH; separate occupancy counter.
- Reset:
  - head=tail=count=0.
  - upd_ld=0, upd_br_en=0, upd_pc=0, mispredict=0, redirect_pc=0, resolve_err=0.
  - Reset wins over all inputs in the same cycle.
- alloc_ready = (count < DEPTH), combinational from registered count only; no same-cycle bypass from a resolve.
- Allocation: alloc_valid && alloc_ready writes the entry at tail and increments tail. alloc_valid while full is dropped; no state change.
- Resolution: resolve_valid && count>0 consumes the head entry.
  - Mispredict condition: (pred != resolve_taken) || (pred && resolve_taken && target != resolve_target).
- Outputs are registered, one-cycle latency from the resolve cycle:
  - upd_ld=1, upd_br_en=resolve_taken, upd_pc=entry pc.
  - mispredict=1 on the mispredict condition.
  - redirect_pc = resolve_target if taken, else entry pc + 4 (32-bit wrap).
- Pulses last exactly one cycle. Back-to-back resolves give back-to-back pulses.
- Mispredict flush: in the resolve cycle that detects a mispredict, all entries (including younger ones) are discarded; next state head=tail=0, count=0. An alloc_valid in that same cycle is dropped.
- Simultaneous allocate and correct resolve: both take effect; count unchanged. Legal when full (alloc_ready still 0, so no allocation occurs).
- Empty resolve: resolve_valid with count=0 is ignored (no upd_ld). resolve_err sets and holds until rst.
- count: +1 on alloc only, -1 on resolve only, unchanged on both, 0 on flush.

Optional Feature:
- Macro BRQ_STATS_EN.
- Defined:
  - Adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - Each increments on the cycle upd_ld / mispredict is asserted.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then alloc pc=0x100 pred=0, next cycle resolve taken=0 -> one cycle later upd_ld=1, upd_br_en=0, upd_pc=0x100, mispredict=0, count back to 0.
- Alloc 4 entries (DEPTH=4) -> alloc_ready=0, count=4. 5th alloc with pc=0x500 is dropped. Resolve all 4 correctly -> upd_pc sequence matches allocation order.
- Alloc pc=0x200 pred=0 plus two younger entries; resolve head taken=1 target=0x400 -> mispredict=1, redirect_pc=0x400, upd_br_en=1, count=0 next cycle.
- Alloc pc=0x300 pred=1 target=0x340; resolve taken=1 target=0x380 -> mispredict=1, redirect_pc=0x380. Repeat with pred=1, taken=0 -> redirect_pc=0x304.
- Full queue, simultaneous alloc and correct resolve -> allocation dropped, count=3. Simultaneous alloc and mispredicting resolve -> count=0, allocation dropped.
- Resolve while empty -> no upd_ld, resolve_err=1 and stays set. With BRQ_STATS_EN: after 3 resolves with 1 mispredict, stat_resolved=3, stat_mispred=1.
